// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, control steps, widths
// and the instruction ROM contents.
package control_unit_pkg;

  localparam int WIDTH         = 32;
  localparam int CONST_OPERAND = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  // Four-entry program: one instruction of each kind, in opcode order.
  function automatic opcode_t rom_read(input logic [1:0] addr);
    opcode_t op;
    case (addr)
      2'd0:    op = OP_ADD;
      2'd1:    op = OP_SUB;
      2'd2:    op = OP_MUL;
      default: op = OP_DIV;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_interface.sv
// Combinational ALU driven by one-hot operation strobes; idle strobes give 0.
// Unsigned arithmetic throughout, division by zero saturates to all-ones.
module alu_interface #(
  parameter int WIDTH = control_unit_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add,
  input  logic             sub,
  input  logic             mul,
  input  logic             div,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    if (add) begin
      result = a + b;
    end else if (sub) begin
      result = a - b;
    end else if (mul) begin
      result = a * b;
    end else if (div) begin
      result = (b == '0) ? '1 : a / b;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Five-step microsequenced datapath: loads two operands, runs one ROM
// instruction through the ALU and presents the result on the bus in T4.
module control_unit #(
  parameter int WIDTH = control_unit_pkg::WIDTH,
  parameter int STEPS = 5
) (
  input  logic             Clock,
  input  logic             reset_n,
  input  logic [1:0]       StartAddress,
  input  logic [WIDTH-1:0] Number1,
  input  logic [WIDTH-1:0] Number2,
  output logic             R1in,
  output logic             R1out,
  output logic             R2in,
  output logic             R2out,
  output logic             Add,
  output logic             Sub,
  output logic             Mul,
  output logic             Div,
  output logic             SelectY,
  output logic             Yin,
  output logic             Zin,
  output logic             Zout,
  output logic [WIDTH-1:0] Register,
  output logic [1:0]       InstructionCode,
  output logic             Done
);

  import control_unit_pkg::*;

  localparam step_t            LAST_STEP = step_t'(3'(STEPS - 1));
  localparam logic [WIDTH-1:0] CONST_A   = WIDTH'(CONST_OPERAND);

  step_t            step_reg, step_next;
  logic [1:0]       pc_reg;
  logic [WIDTH-1:0] r1_reg, r2_reg, y_reg, z_reg;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_result;
  opcode_t          opcode;

  assign opcode          = rom_read(pc_reg);
  assign InstructionCode = opcode;
  assign Register        = bus;
  assign alu_a           = SelectY ? y_reg : CONST_A;

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      step_reg <= T0;
    end else begin
      step_reg <= step_next;
    end
  end

  // Strobes and bus source are gated by reset_n so everything reads 0 while
  // reset is held, even though the step register already sits at T0.
  always_comb begin
    step_next = (step_reg == LAST_STEP) ? T0 : step_t'(step_reg + 3'd1);
    R1in      = 1'b0;
    R1out     = 1'b0;
    R2in      = 1'b0;
    R2out     = 1'b0;
    Add       = 1'b0;
    Sub       = 1'b0;
    Mul       = 1'b0;
    Div       = 1'b0;
    SelectY   = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zout      = 1'b0;
    Done      = 1'b0;
    bus       = '0;
    if (reset_n) begin
      case (step_reg)
        T0: begin
          R1in = 1'b1;
          bus  = Number1;
        end
        T1: begin
          R2in = 1'b1;
          bus  = Number2;
        end
        T2: begin
          R1out = 1'b1;
          Yin   = 1'b1;
          bus   = r1_reg;
        end
        T3: begin
          R2out   = 1'b1;
          SelectY = 1'b1;
          Zin     = 1'b1;
          bus     = r2_reg;
          case (opcode)
            OP_ADD:  Add = 1'b1;
            OP_SUB:  Sub = 1'b1;
            OP_MUL:  Mul = 1'b1;
            default: Div = 1'b1;
          endcase
        end
        T4: begin
          Zout = 1'b1;
          Done = 1'b1;
          bus  = z_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg <= StartAddress;
      r1_reg <= '0;
      r2_reg <= '0;
      y_reg  <= '0;
      z_reg  <= '0;
    end else begin
      if (step_reg == LAST_STEP) pc_reg <= pc_reg + 2'd1;
      if (R1in) r1_reg <= bus;
      if (R2in) r2_reg <= bus;
      if (Yin)  y_reg  <= bus;
      if (Zin)  z_reg  <= alu_result;
    end
  end

  alu_interface #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (bus),
    .add    (Add),
    .sub    (Sub),
    .mul    (Mul),
    .div    (Div),
    .result (alu_result)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table of instructions checked step by
// step through a scoreboard queue, plus reset-abort and late-operand sequences.
module tb_control_unit;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   StartAddress = 2'd0;
  logic [W-1:0] Number1 = '0;
  logic [W-1:0] Number2 = '0;
  logic R1in, R1out, R2in, R2out, Add, Sub, Mul, Div;
  logic SelectY, Yin, Zin, Zout, Done;
  logic [W-1:0] Register;
  logic [1:0]   InstructionCode;

  always #5 Clock = ~Clock;

  control_unit #(.WIDTH(W), .STEPS(5)) dut (
    .Clock(Clock), .reset_n(reset_n), .StartAddress(StartAddress),
    .Number1(Number1), .Number2(Number2),
    .R1in(R1in), .R1out(R1out), .R2in(R2in), .R2out(R2out),
    .Add(Add), .Sub(Sub), .Mul(Mul), .Div(Div),
    .SelectY(SelectY), .Yin(Yin), .Zin(Zin), .Zout(Zout),
    .Register(Register), .InstructionCode(InstructionCode), .Done(Done)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] bus;
    logic [12:0]  ctrl;
    logic [1:0]   code;
  } exp_t;

  typedef struct {
    logic         rst;
    logic [1:0]   start;
    logic [W-1:0] n1;
    logic [W-1:0] n2;
    logic [1:0]   op;
    logic [W-1:0] res;
    logic         late;
    logic [W-1:0] n1_late;
  } vec_t;

  exp_t sb[$];

  logic [12:0] act_ctrl;
  assign act_ctrl = {R1in, R1out, R2in, R2out, Add, Sub, Mul, Div,
                     SelectY, Yin, Zin, Zout, Done};

  // Bit order: R1in R1out R2in R2out Add Sub Mul Div SelectY Yin Zin Zout Done
  function automatic logic [12:0] exp_ctrl(input int s, input logic [1:0] op);
    logic [12:0] r;
    r = '0;
    case (s)
      0: r[12] = 1'b1;
      1: r[10] = 1'b1;
      2: begin r[11] = 1'b1; r[3] = 1'b1; end
      3: begin r[9] = 1'b1; r[4] = 1'b1; r[2] = 1'b1; r[8 - int'(op)] = 1'b1; end
      4: begin r[1] = 1'b1; r[0] = 1'b1; end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_now(input string name, input exp_t e);
    exp_t x;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    cmp({name, " bus"},  Register, x.bus);
    cmp({name, " ctrl"}, W'(act_ctrl), W'(x.ctrl));
    cmp({name, " code"}, W'(InstructionCode), W'(x.code));
  endtask

  task automatic check_idle(input string name, input logic [1:0] code);
    exp_t e;
    e.bus = '0; e.ctrl = '0; e.code = code;
    check_now(name, e);
  endtask

  task automatic do_reset(input logic [1:0] start);
    @(negedge Clock);
    StartAddress = start;
    reset_n = 1'b0;
    check_idle("reset", start);
    @(negedge Clock);
    reset_n = 1'b1;
  endtask

  // Entered at a falling edge with the DUT in T0; leaves at the next T0.
  task automatic run_instr(input int idx, input vec_t v);
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      if (s == 2 && v.late) Number1 = v.n1_late;
      case (s)
        0, 2:    e.bus = v.n1;
        1, 3:    e.bus = v.n2;
        default: e.bus = v.res;
      endcase
      e.ctrl = exp_ctrl(s, v.op);
      e.code = v.op;
      check_now($sformatf("instr%0d T%0d", idx, s), e);
      @(negedge Clock);
    end
    $display("[TB] instr %0d op=%0d n1=%h n2=%h expect=%h", idx, v.op, v.n1, v.n2, v.res);
  endtask

  // Per-cycle structural invariants: one ALU strobe at most, one bus driver.
  always @(negedge Clock) begin
    #2;
    if (reset_n) begin
      tests++;
      if (!$onehot0({Add, Sub, Mul, Div}) ||
          $countones({R1in, R2in, R1out, R2out, Zout}) != 1) begin
        fails++;
        $display("[TB] FAIL invariant: strobes=%b drivers=%b", {Add, Sub, Mul, Div},
                 {R1in, R2in, R1out, R2out, Zout});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t vecs[11];
  vec_t v;
  exp_t e3;

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 32'd5, 32'd6, 2'd0, 32'd11, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 2'd0, 32'd5, 32'd6, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 2'd0, 32'd5, 32'd6, 2'd2, 32'd30, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 2'd0, 32'd5, 32'd6, 2'd3, 32'd0, 1'b0, 32'd0};
    vecs[4]  = '{1'b0, 2'd0, 32'd5, 32'd6, 2'd0, 32'd11, 1'b0, 32'd0};
    vecs[5]  = '{1'b1, 2'd3, 32'd8, 32'd0, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'd0};
    vecs[6]  = '{1'b1, 2'd2, 32'd7, 32'd3, 2'd2, 32'd21, 1'b0, 32'd0};
    vecs[7]  = '{1'b1, 2'd1, 32'd3, 32'd9, 2'd1, 32'hFFFF_FFFA, 1'b0, 32'd0};
    vecs[8]  = '{1'b1, 2'd3, 32'd100, 32'd7, 2'd3, 32'd14, 1'b0, 32'd0};
    vecs[9]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'd2, 2'd0, 32'd1, 1'b0, 32'd0};
    vecs[10] = '{1'b1, 2'd0, 32'd5, 32'd6, 2'd0, 32'd11, 1'b1, 32'd100};

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      Number1 = v.n1;
      Number2 = v.n2;
      if (v.rst) do_reset(v.start);
      run_instr(i, v);
    end

    // Reset asserted during T3 aborts the instruction; restart at a new address.
    Number1 = 32'd5;
    Number2 = 32'd6;
    do_reset(2'd0);
    repeat (3) @(negedge Clock);
    e3.bus = 32'd6; e3.ctrl = exp_ctrl(3, 2'd0); e3.code = 2'd0;
    check_now("abort T3", e3);
    StartAddress = 2'd2;
    #2;
    reset_n = 1'b0;
    check_idle("abort immediate", 2'd2);
    @(posedge Clock);
    check_idle("abort held", 2'd2);
    @(negedge Clock);
    reset_n = 1'b1;
    v = '{1'b0, 2'd2, 32'd5, 32'd6, 2'd2, 32'd30, 1'b0, 32'd0};
    run_instr(11, v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
